copr_ctrl: RTL and testbench

Control sequencer ahead of the coprocessor stream front end. It pulls a two-word job descriptor (header, burst exponent) from the shared FSL slave channel and latches size and sizeburst. It then clears the front-end size counter, holds start for the duration of the job, and returns to descriptor fetch on job completion or on watchdog timeout. It drives rd_FSMctrl; the front end ORs it with its own read into FSL_S_READ.

---
 rtl/copr_ctrl_pkg.sv | 24 ++
 rtl/copr_watchdog.sv | 39 +++
 rtl/copr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_copr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/copr_ctrl_pkg.sv
// copr_ctrl_pkg
// Shared definitions for the coprocessor control sequencer:
//   state_t    - sequencer state encoding
//   OPC_RUN    - header opcode that launches a job
//   OPC_WIDTH  - width of the opcode field at the top of a header word
//   opc_lsb()  - bit position of the opcode field's LSB for a given data width
package copr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BURST,
        ST_CLR,
        ST_RUN
    } state_t;

    localparam logic [3:0] OPC_RUN   = 4'h1;
    localparam int         OPC_WIDTH = 4;

    function automatic int opc_lsb(input int data_width);
        return data_width - OPC_WIDTH;
    endfunction

endpackage

// File: rtl/copr_watchdog.sv
// copr_watchdog
// RUN-state watchdog: a binary up-counter that is zeroed by clr, advances
// while en is high and flags expiry once it has reached TIMEOUT-1.
// Only instantiated when TIMEOUT is nonzero.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (takes priority over en)
//   en        - count enable
//   expired   - high while the count equals TIMEOUT-1
module copr_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TOW     = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TOW-1:0] count;

    // Counter register: clear wins over enable so the count always starts
    // from zero on RUN entry, regardless of any stray enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expiry compare on the current count; the caller samples it in the same
    // cycle, so RUN lasts exactly TIMEOUT cycles when nothing completes.
    assign expired = (count == TOW'(TIMEOUT - 1));

endmodule

// File: rtl/copr_ctrl.sv
// copr_ctrl
// Control sequencer ahead of the coprocessor stream front end. Fetches a
// two-word descriptor (header, burst exponent) from the FSL slave channel,
// pulses clear to the front-end size counter, then holds start until the
// back end reports job_done or the watchdog expires.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   FSL_S_EXISTS  - FSL slave has a word available
//   FSL_S_DATA    - FSL slave data word
//   rd_FSMctrl    - FSL read strobe for descriptor words (HDR/BURST only)
//   clear         - one-cycle clear to the front-end size counter
//   start         - job active level
//   size          - latched job size
//   sizeburst     - latched burst exponent
//   job_done      - one-cycle pulse from the back end, honoured in RUN only
//   busy          - high in every state except IDLE
//   err_timeout   - sticky watchdog error, cleared by the next valid header
//   jobs          - completed-job counter, wraps modulo 256
module copr_ctrl
    import copr_ctrl_pkg::*;
#(
    parameter int SIZECOUNT = 12,
    parameter int SIZEBURST = 8,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 4096,
    parameter int TOW       = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FSL_S_EXISTS,
    input  logic [DATAWIDTH-1:0] FSL_S_DATA,
    output logic                 rd_FSMctrl,
    output logic                 clear,
    output logic                 start,
    output logic [SIZECOUNT-1:0] size,
    output logic [SIZEBURST-1:0] sizeburst,
    input  logic                 job_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [7:0]           jobs
);

    state_t state_q;
    state_t state_d;

    logic hdr_valid;
    logic hdr_accept;
    logic burst_accept;
    logic job_finish;
    logic job_timeout;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;
    logic unused_data;

    // Only the opcode and size fields of the header matter; the bits in
    // between are reserved and deliberately ignored.
    assign unused_data = ^FSL_S_DATA;

    assign hdr_valid = (FSL_S_DATA[opc_lsb(DATAWIDTH) +: OPC_WIDTH] == OPC_RUN) &&
                       (FSL_S_DATA[SIZECOUNT-1:0] != '0);

    // The watchdog is zeroed while in CLR so it starts at 0 on RUN entry, and
    // it only advances in RUN cycles that do not complete the job.
    assign wd_clr = (state_q == ST_CLR);
    assign wd_en  = (state_q == ST_RUN) && !job_done;

    generate
        if (TIMEOUT != 0) begin : g_wd
            copr_watchdog #(
                .TIMEOUT (TIMEOUT),
                .TOW     (TOW)
            ) u_wd (
                .clk     (clk),
                .rst     (rst),
                .clr     (wd_clr),
                .en      (wd_en),
                .expired (wd_expired)
            );
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. The read strobe follows EXISTS
    // combinationally in HDR/BURST so a word is consumed in the same cycle it
    // is sampled; in RUN the channel belongs to the front end, so the strobe
    // stays low. job_done beats a simultaneous watchdog expiry.
    always_comb begin
        state_d      = state_q;
        rd_FSMctrl   = 1'b0;
        clear        = 1'b0;
        start        = 1'b0;
        busy         = 1'b1;
        hdr_accept   = 1'b0;
        burst_accept = 1'b0;
        job_finish   = 1'b0;
        job_timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy    = 1'b0;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                rd_FSMctrl = FSL_S_EXISTS;
                if (FSL_S_EXISTS && hdr_valid) begin
                    hdr_accept = 1'b1;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                rd_FSMctrl = FSL_S_EXISTS;
                if (FSL_S_EXISTS) begin
                    burst_accept = 1'b1;
                    state_d      = ST_CLR;
                end
            end
            ST_CLR: begin
                clear   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                start = 1'b1;
                if (job_done) begin
                    job_finish = 1'b1;
                    state_d    = ST_HDR;
                end else if (wd_expired) begin
                    job_timeout = 1'b1;
                    state_d     = ST_HDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Descriptor latches and status. size/sizeburst only change on an accepted
    // descriptor word, so they hold steady for the whole of RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size        <= '0;
            sizeburst   <= '0;
            jobs        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (hdr_accept) begin
                size        <= FSL_S_DATA[SIZECOUNT-1:0];
                err_timeout <= 1'b0;
            end
            if (burst_accept) begin
                sizeburst <= FSL_S_DATA[SIZEBURST-1:0];
            end
            if (job_finish) begin
                jobs <= jobs + 8'd1;
            end
            if (job_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_copr_ctrl.sv
// tb_copr_ctrl
// Directed bench for copr_ctrl. Instance "a" uses the default watchdog limit
// for the normal job, bad-header, starved-channel and reset cases; instance
// "b" uses a 16-cycle watchdog for the timeout and tie cases.
module tb_copr_ctrl;

    logic        clk;
    logic        rst;

    logic        ex_a;
    logic [31:0] dat_a;
    logic        jd_a;
    logic        rd_a;
    logic        clear_a;
    logic        start_a;
    logic [11:0] size_a;
    logic [7:0]  sb_a;
    logic        busy_a;
    logic        err_a;
    logic [7:0]  jobs_a;

    logic        ex_b;
    logic [31:0] dat_b;
    logic        jd_b;
    logic        rd_b;
    logic        clear_b;
    logic        start_b;
    logic [11:0] size_b;
    logic [7:0]  sb_b;
    logic        busy_b;
    logic        err_b;
    logic [7:0]  jobs_b;

    int checks;
    int errors;
    int cnt;

    copr_ctrl dut_a (
        .clk          (clk),
        .rst          (rst),
        .FSL_S_EXISTS (ex_a),
        .FSL_S_DATA   (dat_a),
        .rd_FSMctrl   (rd_a),
        .clear        (clear_a),
        .start        (start_a),
        .size         (size_a),
        .sizeburst    (sb_a),
        .job_done     (jd_a),
        .busy         (busy_a),
        .err_timeout  (err_a),
        .jobs         (jobs_a)
    );

    copr_ctrl #(
        .TIMEOUT (16),
        .TOW     (5)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .FSL_S_EXISTS (ex_b),
        .FSL_S_DATA   (dat_b),
        .rd_FSMctrl   (rd_b),
        .clear        (clear_b),
        .start        (start_b),
        .size         (size_b),
        .sizeburst    (sb_b),
        .job_done     (jd_b),
        .busy         (busy_b),
        .err_timeout  (err_b),
        .jobs         (jobs_b)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance's inputs and let combinational outputs settle.
    task automatic applyStimulus(input bit which, input logic e,
                                 input logic [31:0] d, input logic j);
        if (which == 1'b0) begin
            ex_a  = e;
            dat_a = d;
            jd_a  = j;
        end else begin
            ex_b  = e;
            dat_b = d;
            jd_b  = j;
        end
        #1;
    endtask

    // Count a comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ex_a = 1'b0; dat_a = '0; jd_a = 1'b0;
        ex_b = 1'b0; dat_b = '0; jd_b = 1'b0;

        // Reset state
        waitCycle();
        waitCycle();
        checkOutput("rst_start", {31'b0, start_a}, 0);
        checkOutput("rst_clear", {31'b0, clear_a}, 0);
        checkOutput("rst_busy", {31'b0, busy_a}, 0);
        checkOutput("rst_size", {20'b0, size_a}, 0);
        checkOutput("rst_jobs", {24'b0, jobs_a}, 0);
        checkOutput("rst_err", {31'b0, err_a}, 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_busy", {31'b0, busy_a}, 0);
        waitCycle();
        checkOutput("hdr_busy", {31'b0, busy_a}, 1);

        // Basic job
        $display("[TB] basic job");
        applyStimulus(0, 1'b1, 32'h1000_0040, 1'b0);
        checkOutput("t1_rd_hdr", {31'b0, rd_a}, 1);
        waitCycle();
        applyStimulus(0, 1'b1, 32'h0000_0003, 1'b0);
        checkOutput("t1_rd_burst", {31'b0, rd_a}, 1);
        checkOutput("t1_clear_early", {31'b0, clear_a}, 0);
        waitCycle();
        checkOutput("t1_size", {20'b0, size_a}, 32'h40);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_clear", {31'b0, clear_a}, 1);
        checkOutput("t1_start_clr", {31'b0, start_a}, 0);
        checkOutput("t1_sizeburst", {24'b0, sb_a}, 3);
        waitCycle();
        applyStimulus(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("t1_start", {31'b0, start_a}, 1);
        checkOutput("t1_clear_once", {31'b0, clear_a}, 0);
        checkOutput("t1_rd_run", {31'b0, rd_a}, 0);
        repeat (99) waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        checkOutput("t1_start_last", {31'b0, start_a}, 1);
        checkOutput("t1_size_run", {20'b0, size_a}, 32'h40);
        waitCycle();
        checkOutput("t1_start_drop", {31'b0, start_a}, 0);
        checkOutput("t1_jobs", {24'b0, jobs_a}, 1);
        // job_done outside RUN must not count
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_jd_ignored", {24'b0, jobs_a}, 1);

        // Bad headers are consumed and discarded
        $display("[TB] bad header");
        applyStimulus(0, 1'b1, 32'h2000_0010, 1'b0);
        checkOutput("t2_rd_bad_opc", {31'b0, rd_a}, 1);
        waitCycle();
        applyStimulus(0, 1'b1, 32'h1000_0000, 1'b0);
        checkOutput("t2_rd_zero_size", {31'b0, rd_a}, 1);
        checkOutput("t2_size_keep1", {20'b0, size_a}, 32'h40);
        checkOutput("t2_no_clear1", {31'b0, clear_a}, 0);
        waitCycle();
        applyStimulus(0, 1'b1, 32'h1000_0008, 1'b0);
        checkOutput("t2_size_keep2", {20'b0, size_a}, 32'h40);
        checkOutput("t2_no_clear2", {31'b0, clear_a}, 0);
        waitCycle();
        applyStimulus(0, 1'b1, 32'h0000_0002, 1'b0);
        checkOutput("t2_no_clear3", {31'b0, clear_a}, 0);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_clear", {31'b0, clear_a}, 1);
        checkOutput("t2_size", {20'b0, size_a}, 8);
        checkOutput("t2_sizeburst", {24'b0, sb_a}, 2);
        waitCycle();
        checkOutput("t2_clear_once", {31'b0, clear_a}, 0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_jobs", {24'b0, jobs_a}, 2);

        // Starved channel between header and burst
        $display("[TB] starved channel");
        applyStimulus(0, 1'b1, 32'h1000_0020, 1'b0);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0000_0055, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checkOutput("t3_starve", {29'b0, clear_a, rd_a, start_a}, 0);
            waitCycle();
        end
        applyStimulus(0, 1'b1, 32'h0000_0005, 1'b0);
        checkOutput("t3_rd_burst", {31'b0, rd_a}, 1);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_clear", {31'b0, clear_a}, 1);
        checkOutput("t3_size", {20'b0, size_a}, 32'h20);
        checkOutput("t3_sizeburst", {24'b0, sb_a}, 5);
        waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("t3_running", {31'b0, start_a}, 1);

        // Asynchronous reset in the middle of RUN
        $display("[TB] reset mid-run");
        applyStimulus(0, 1'b1, 32'h1000_0099, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_start", {31'b0, start_a}, 0);
        checkOutput("t6_clear", {31'b0, clear_a}, 0);
        checkOutput("t6_size", {20'b0, size_a}, 0);
        checkOutput("t6_sizeburst", {24'b0, sb_a}, 0);
        checkOutput("t6_jobs", {24'b0, jobs_a}, 0);
        checkOutput("t6_busy", {31'b0, busy_a}, 0);
        waitCycle();
        checkOutput("t6_rd_in_rst", {31'b0, rd_a}, 0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        waitCycle();
        applyStimulus(0, 1'b1, 32'h1000_0004, 1'b0);
        checkOutput("t6_fresh_rd", {31'b0, rd_a}, 1);
        waitCycle();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        checkOutput("t6_fresh_size", {20'b0, size_a}, 4);

        // Watchdog timeout on the 16-cycle instance
        $display("[TB] timeout");
        applyStimulus(1, 1'b1, 32'h1000_0010, 1'b0);
        waitCycle();
        applyStimulus(1, 1'b1, 32'h0000_0001, 1'b0);
        waitCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_clear", {31'b0, clear_b}, 1);
        waitCycle();
        cnt = start_b ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            waitCycle();
            if (start_b) cnt++;
            else break;
        end
        checkOutput("t4_start_len", cnt, 16);
        checkOutput("t4_err", {31'b0, err_b}, 1);
        checkOutput("t4_jobs", {24'b0, jobs_b}, 0);
        checkOutput("t4_busy", {31'b0, busy_b}, 1);
        applyStimulus(1, 1'b1, 32'h1000_0010, 1'b0);
        checkOutput("t4_err_held", {31'b0, err_b}, 1);
        waitCycle();
        applyStimulus(1, 1'b1, 32'h0000_0001, 1'b0);
        checkOutput("t4_err_cleared", {31'b0, err_b}, 0);
        waitCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        waitCycle();

        // job_done on the expiry cycle wins
        $display("[TB] tie");
        checkOutput("t5_start", {31'b0, start_b}, 1);
        repeat (15) waitCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_start_last", {31'b0, start_b}, 1);
        waitCycle();
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_jobs", {24'b0, jobs_b}, 1);
        checkOutput("t5_err", {31'b0, err_b}, 0);
        checkOutput("t5_start_drop", {31'b0, start_b}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
